// File: rtl/mult3_rr_sched.sv
// mult3_rr_sched: round-robin scheduler sharing one pipelined 3-input signed
// Q5.10 multiplier between NREQ requesters, with a flush/drain handshake.
// Optional build macro MULT3_SAT_EN: saturate the Q5.10 result instead of
// wrapping when the product overflows.
module mult3_rr_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int PIPE = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [16*NREQ-1:0] op_a,
  input  logic [16*NREQ-1:0] op_b,
  input  logic [16*NREQ-1:0] op_c,
  output logic [NREQ-1:0]    gnt,
  input  logic               flush,
  output logic               flush_done,
  output logic               busy,
  output logic               res_valid,
  output logic [IDW-1:0]     res_id,
  output logic [15:0]        res_data
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [IDW-1:0]        ptr_q, ptr_d;
  logic                  flush_done_q, flush_done_d;
  logic                  res_valid_q, res_valid_d;
  logic [IDW-1:0]        res_id_q, res_id_d;
  logic signed [15:0]    res_data_q, res_data_d;

  int                    win_idx;
  logic                  win_found;
  logic                  issue_vld;
  logic [IDW-1:0]        issue_id;
  logic signed [15:0]    issue_a, issue_b, issue_c;
  logic signed [31:0]    issue_ab;

  logic                  fin_vld;
  logic [IDW-1:0]        fin_id;
  logic signed [47:0]    fin_prod;
  logic                  int_busy;

  // Q15.30 -> Q5.10: drop 20 LSBs; optionally clamp when bits [47:35] disagree
  function automatic logic signed [15:0] scale_fn(input logic signed [47:0] p);
`ifdef MULT3_SAT_EN
    if (p[47:35] != {13{p[47]}}) begin
      return p[47] ? 16'sh8000 : 16'sh7FFF;
    end
    return p[35:20];
`else
    return p[35:20];
`endif
  endfunction

`ifdef MULT3_SAT_EN
  logic unused_prod_bits;
  assign unused_prod_bits = ^fin_prod[19:0];
`else
  logic unused_prod_bits;
  assign unused_prod_bits = ^{fin_prod[47:36], fin_prod[19:0]};
`endif

  // Round-robin arbitration: first request above the pointer wins, then issue mux
  always_comb begin
    win_found = 1'b0;
    win_idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!win_found && (i == ((int'(ptr_q) + k) % NREQ)) && req[i]) begin
          win_found = 1'b1;
          win_idx   = i;
        end
      end
    end
    issue_vld = (state_q == RUN) && !flush && win_found;
    issue_id  = IDW'(win_idx);
    gnt       = '0;
    issue_a   = '0;
    issue_b   = '0;
    issue_c   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (i == win_idx) begin
        gnt[i]  = issue_vld;
        issue_a = op_a[16*i +: 16];
        issue_b = op_b[16*i +: 16];
        issue_c = op_c[16*i +: 16];
      end
    end
    ptr_d = issue_vld ? issue_id : ptr_q;
  end

  // First half of the multiply happens in the issue cycle
  assign issue_ab = 32'(issue_a) * 32'(issue_b);

  if (PIPE == 1) begin : g_direct
    // Single-cycle: the whole product lands in the result register
    assign fin_vld  = issue_vld;
    assign fin_id   = issue_id;
    assign fin_prod = 48'(issue_ab) * 48'(issue_c);
    assign int_busy = 1'b0;
  end else begin : g_stages
    localparam int NS = PIPE - 1;
    logic               vld_q [NS];
    logic               vld_d [NS];
    logic [IDW-1:0]     id_q  [NS];
    logic [IDW-1:0]     id_d  [NS];
    logic signed [31:0] ab_q  [NS];
    logic signed [31:0] ab_d  [NS];
    logic signed [15:0] c_q   [NS];
    logic signed [15:0] c_d   [NS];

    // Stage shift: p0 captures A*B and C at issue, later stages delay them
    always_comb begin
      vld_d[0] = issue_vld;
      id_d[0]  = issue_id;
      ab_d[0]  = issue_ab;
      c_d[0]   = issue_c;
      for (int k = 1; k < NS; k++) begin
        vld_d[k] = vld_q[k-1];
        id_d[k]  = id_q[k-1];
        ab_d[k]  = ab_q[k-1];
        c_d[k]   = c_q[k-1];
      end
    end

    // Stage registers; only the valid bits are reset
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int k = 0; k < NS; k++) vld_q[k] <= 1'b0;
      end else begin
        vld_q <= vld_d;
      end
      id_q <= id_d;
      ab_q <= ab_d;
      c_q  <= c_d;
    end

    // Any valid stage counts as work in flight
    always_comb begin
      int_busy = 1'b0;
      for (int k = 0; k < NS; k++) int_busy = int_busy | vld_q[k];
    end

    assign fin_vld  = vld_q[NS-1];
    assign fin_id   = id_q[NS-1];
    assign fin_prod = 48'(ab_q[NS-1]) * 48'(c_q[NS-1]);
  end

  // Control FSM: IDLE waits for flush low, RUN issues, DRAIN empties the pipe
  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      IDLE:    if (!flush) state_d = RUN;
      RUN:     if (flush)  state_d = DRAIN;
      DRAIN: begin
        if (!int_busy) begin
          state_d      = IDLE;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result register: id/data hold their last value when no result arrives
  always_comb begin
    res_valid_d = fin_vld;
    res_id_d    = fin_vld ? fin_id : res_id_q;
    res_data_d  = fin_vld ? scale_fn(fin_prod) : res_data_q;
  end

  // Control and output state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= IDW'(NREQ - 1);
      flush_done_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_id_q     <= '0;
      res_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      flush_done_q <= flush_done_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      res_data_q   <= res_data_d;
    end
  end

  assign flush_done = flush_done_q;
  assign busy       = int_busy | res_valid_q;
  assign res_valid  = res_valid_q;
  assign res_id     = res_id_q;
  assign res_data   = res_data_q;

endmodule

// File: tb/tb_mult3_rr_sched.sv
// Bench for mult3_rr_sched: scoreboard of expected results pushed on each
// observed grant, popped and compared when res_valid appears.
module tb_mult3_rr_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int PIPE = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [16*NREQ-1:0] op_a = '0, op_b = '0, op_c = '0;
  logic [NREQ-1:0]    gnt;
  logic               flush = 1'b0;
  logic               flush_done, busy, res_valid;
  logic [IDW-1:0]     res_id;
  logic [15:0]        res_data;

  mult3_rr_sched #(.NREQ(NREQ), .IDW(IDW), .PIPE(PIPE)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .gnt(gnt), .flush(flush), .flush_done(flush_done), .busy(busy),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data)
  );

  always #5 clk = ~clk;

  typedef struct {int id; logic [15:0] data; int cyc;} exp_t;
  exp_t sb[$];
  int   gnt_log[$];
  int   cyc = 0;
  int   n_cmp = 0, n_err = 0;
  int   last_res_cyc = 0, fd_cnt = 0, fd_cyc = 0;
  logic fd_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: full signed product, Q15.30 back to Q5.10
  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c);
    longint     p;
    logic [63:0] pu;
    p  = longint'($signed(a)) * longint'($signed(b)) * longint'($signed(c));
    pu = p;
`ifdef MULT3_SAT_EN
    if (p >= (64'sd1 <<< 35)) return 16'h7FFF;
    if (p < -(64'sd1 <<< 35)) return 16'h8000;
`endif
    return pu[35:20];
  endfunction

  // Monitor: push expectation on grant, compare on result
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (gnt != '0) begin
        check_val("gnt_onehot", $countones(gnt), 1);
        for (int i = 0; i < NREQ; i++) begin
          if (gnt[i]) begin
            e.id   = i;
            e.data = model(op_a[16*i +: 16], op_b[16*i +: 16], op_c[16*i +: 16]);
            e.cyc  = cyc + PIPE;
            sb.push_back(e);
            gnt_log.push_back(i);
          end
        end
      end
      if (res_valid) begin
        last_res_cyc = cyc;
        if (sb.size() == 0) begin
          check_val("res_unexpected", res_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          check_val("res_id", res_id, e.id);
          check_val("res_data", res_data, e.data);
          check_val("res_cycle", cyc, e.cyc);
        end
      end
      if (flush_done) begin
        fd_cnt++;
        fd_cyc  = cyc;
        fd_busy = busy;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c);
    op_a[16*i +: 16] = a;
    op_b[16*i +: 16] = b;
    op_c[16*i +: 16] = c;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    req   = '0;
    flush = 1'b0;
    repeat (n) step();
    sb.delete();
    gnt_log.delete();
    rst_n = 1'b1;
  endtask

  task automatic await_grant(input int idx, input string tag);
    bit              got  = 1'b0;
    logic [NREQ-1:0] seen = '0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (gnt != '0) begin
        got  = 1'b1;
        seen = gnt;
      end
    end
    check_val({tag, "_seen"}, got, 1);
    check_val(tag, seen, 1 << idx);
    @(posedge clk);
    #1;
    req = req & ~seen;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 40; n++) begin
      if (sb.size() == 0 && !busy) break;
      step();
    end
    check_val("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) step();
    @(negedge clk);
    check_val("rst_res_valid", res_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_gnt", gnt, 0);
    check_val("rst_flush_done", flush_done, 0);
    check_val("rst_res_id", res_id, 0);
    check_val("rst_res_data", res_data, 0);
    step();
    sb.delete();
    rst_n = 1'b1;

    // Single request: 2.0 * 1.5 * 0.5 = 1.5
    set_ops(0, 16'h0800, 16'h0600, 16'h0200);
    req[0] = 1'b1;
    await_grant(0, "g_single");
    wait_drain();
    check_val("single_hold_valid", res_valid, 0);
    check_val("single_hold_data", res_data, 16'h0600);
    check_val("single_hold_id", res_id, 0);

    // Sign: -1.0 * 1.0 * 1.0
    set_ops(2, 16'hFC00, 16'h0400, 16'h0400);
    req[2] = 1'b1;
    await_grant(2, "g_sign");
    wait_drain();
    check_val("sign_data", res_data, 16'hFC00);
    check_val("sign_id", res_id, 2);

    // All four requesting for 8 grant cycles after reset
    do_reset(2);
    for (int i = 0; i < NREQ; i++)
      set_ops(i, 16'($urandom), 16'($urandom_range(0, 16'h0FFF)), 16'($urandom));
    req = '1;
    repeat (9) step();
    req = '0;
    check_val("rr_count", gnt_log.size(), 8);
    for (int k = 0; k < 8 && k < gnt_log.size(); k++)
      check_val("rr_order", gnt_log[k], k % NREQ);
    wait_drain();

    // Flush with two ops in flight (pointer now at 3)
    set_ops(0, 16'h0C00, 16'hF800, 16'h0100);
    set_ops(1, 16'h0400, 16'h0A00, 16'hFE00);
    req = 4'b0011;
    @(negedge clk);
    check_val("fl_gnt0", gnt, 4'b0001);
    step();
    req[0] = 1'b0;
    @(negedge clk);
    check_val("fl_gnt1", gnt, 4'b0010);
    step();
    set_ops(2, 16'h0200, 16'h0300, 16'h0400);
    set_ops(0, 16'h0100, 16'h0100, 16'h0100);
    req     = 4'b0101;
    flush   = 1'b1;
    fd_cnt  = 0;
    gnt_log.delete();
    @(negedge clk);
    check_val("fl_flush_wins", gnt, 0);
    repeat (PIPE + 4) step();
    check_val("fl_no_grants", gnt_log.size(), 0);
    check_val("fl_done_once", fd_cnt, 1);
    check_val("fl_done_after_res", fd_cyc, last_res_cyc + 1);
    check_val("fl_done_busy", fd_busy, 0);
    check_val("fl_sb_empty", sb.size(), 0);
    flush = 1'b0;
    await_grant(2, "fl_resume_ptr");
    await_grant(0, "fl_resume_next");
    wait_drain();

    // Overflow corners
    set_ops(1, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    req[1] = 1'b1;
    await_grant(1, "g_ovf_pos");
    wait_drain();
`ifdef MULT3_SAT_EN
    check_val("sat_pos", res_data, 16'h7FFF);
`endif
    set_ops(3, 16'h8000, 16'h7FFF, 16'h7FFF);
    req[3] = 1'b1;
    await_grant(3, "g_ovf_neg");
    wait_drain();
`ifdef MULT3_SAT_EN
    check_val("sat_neg", res_data, 16'h8000);
`endif

    // Reset for one cycle with the pipeline full
    for (int i = 0; i < NREQ; i++)
      set_ops(i, 16'($urandom), 16'($urandom), 16'($urandom));
    req = '1;
    repeat (PIPE + 1) step();
    @(negedge clk);
    check_val("pre_rst_busy", busy, 1);
    step();
    rst_n = 1'b0;
    req   = '0;
    step();
    sb.delete();
    gnt_log.delete();
    rst_n = 1'b1;
    @(negedge clk);
    check_val("mid_rst_valid", res_valid, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_gnt", gnt, 0);
    req = '1;
    await_grant(0, "post_rst_first");
    req = '0;
    wait_drain();
    repeat (3) step();
    check_val("sb_final", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mult3_rr_sched.md
Name: mult3_rr_sched

Overview:
- Round-robin scheduler that shares one 3-input signed fixed-point multiplier between NREQ requesters.
- Typical use: several sigmoid or neuron lanes that each need A*B*C.
- Arbitrates requests, issues one operand triple per cycle into an internal pipelined 3-input multiply, and returns each result tagged with its requester ID.
- Provides a flush handshake that stops issue and drains the pipeline before a layer or configuration change.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of the requester ID; must satisfy 2**IDW >= NREQ
- PIPE, 2, multiply pipeline depth in cycles, grant to result (1..4)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req  in  NREQ  per-requester request level; held until granted
- op_a  in  16*NREQ  operand A of requester i at bits [16i+15:16i], signed Q5.10
- op_b  in  16*NREQ  operand B, same packing and format
- op_c  in  16*NREQ  operand C, same packing and format
- gnt  out  NREQ  one-hot grant; operands of the granted requester are sampled at this clock edge
- flush  in  1  level; request to stop issuing and drain
- flush_done  out  1  one-cycle pulse when the pipeline is empty after a flush
- busy  out  1  high while any operation is in flight
- res_valid  out  1  result strobe
- res_id  out  IDW  requester index of the result
- res_data  out  16  signed Q5.10 product

Behaviour:
- Reset:
  - Applies on a clk edge with rst_n=0.
  - All outputs go to 0; all pipeline valid bits are cleared.
  - RR pointer goes to NREQ-1, so requester 0 has first priority.
  - FSM goes to IDLE.
  - Operations in flight when reset hits mid-operation are discarded; no res_valid is produced for them.
- Grant (combinational from registered state and req):
  - gnt is nonzero only in state RUN.
  - The winner is the first set req bit searching from pointer+1 upward, wrapping modulo NREQ.
  - At most one grant per cycle.
  - The pointer updates to the winner index only on a grant.
  - A requester seeing gnt[i]=1 deasserts or changes its operands next cycle.
- Latency: a grant at cycle t gives res_valid=1 at cycle t+PIPE, with res_id equal to the granted index. Throughput is 1 result per cycle; results are in issue order.
- Arithmetic:
  - Full 48-bit signed product A*B*C.
  - res_data = product[35:20] (Q5.10 x3 gives Q15.30; dropping 20 LSBs returns Q5.10).
  - Default: truncation toward minus infinity, high bits discarded (wraps on overflow).
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN: first cycle after reset release.
  - RUN -> DRAIN: flush=1. No grant is issued in a cycle where flush=1.
  - DRAIN: no grants; in-flight results still emerge normally.
  - DRAIN -> IDLE: pipeline empty. flush_done pulses for 1 cycle on the transition.
  - IDLE -> RUN: flush=0. If flush stays 1, the FSM stays in IDLE with gnt=0 and flush_done is not repeated.
- busy = OR of all pipeline valid bits.
- Simultaneous events:
  - flush and req in the same cycle: flush wins, no grant.
  - A request from the requester just granted is serviced again only after all other pending requesters have been served.
  - An empty pipeline when flush arrives gives DRAIN for 1 cycle, then the flush_done pulse.
- res_valid/res_id/res_data are registered. res_data and res_id hold their last value when res_valid=0.

Optional Feature:
- Macro MULT3_SAT_EN.
- Defined: one extra output check in the final stage.
  - If product[47:35] are not all equal, res_data saturates: 0x7FFF when the product is positive, 0x8000 when negative.
  - Latency is unchanged.
- Undefined: plain bit-slice product[35:20], wrapping on overflow.

Test Plan:
- Single request: requester 0 with A=0x0800 (2.0), B=0x0600 (1.5), C=0x0200 (0.5).
  -> gnt=0001, then PIPE cycles later res_valid=1, res_id=0, res_data=0x0600 (1.5).
- Sign: requester 2 with A=0xFC00 (-1.0), B=0x0400, C=0x0400.
  -> res_data=0xFC00, res_id=2.
- All four req held high for 8 cycles after reset.
  -> grant order 0,1,2,3,0,1,2,3; results back-to-back with matching res_id.
- Flush with 2 ops in flight.
  -> no further gnt; both results emerge; flush_done pulses exactly once, in the cycle after the last res_valid; busy=0 then; after flush drops, granting resumes from pointer+1.
- Overflow: A=B=C=0x7FFF.
  -> without MULT3_SAT_EN, res_data=product[35:20]; with it, res_data=0x7FFF.
  -> A=0x8000, B=C=0x7FFF with MULT3_SAT_EN gives 0x8000.
- Reset with rst_n=0 for 1 cycle while the pipeline is full.
  -> next cycle res_valid=0, busy=0, gnt=0; first grant after release goes to requester 0.
